// File: rtl/hazard_sequencer_pkg.sv
// rtl/hazard_sequencer_pkg.sv - shared state, forwarding and opcode constants for the hazard sequencer
package hazard_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1
  } state_t;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

  localparam logic [4:0] NOP_OP = 5'b00000;

  // Nearest producing stage wins; a killed slot always reads the register file.
  function automatic logic [1:0] fwd_sel(input logic kill, input logic ex_hit, input logic mem_hit);
    if (kill)         return FWD_REG;
    else if (ex_hit)  return FWD_EXMEM;
    else if (mem_hit) return FWD_MEMWB;
    else              return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_sequencer_if.sv
// rtl/hazard_sequencer_if.sv - decode-side inputs and pipeline control outputs of the hazard sequencer
interface hazard_sequencer_if #(parameter int REG_AW = 5);
  logic              valid_dec;
  logic [REG_AW-1:0] RA_dec;
  logic [REG_AW-1:0] RB_dec;
  logic              uses_ra;
  logic              uses_rb;
  logic [REG_AW-1:0] RW_dec;
  logic              wr_en_dec;
  logic              mem_en_dec;
  logic              mem_rw_dec;
  logic              branch_ex;
  logic              stall_if;
  logic              stall_dec;
  logic              bubble_ex;
  logic              flush;
  logic [1:0]        fwd_a_sel;
  logic [1:0]        fwd_b_sel;
  logic [1:0]        state_o;

  modport master (
    output valid_dec, RA_dec, RB_dec, uses_ra, uses_rb, RW_dec,
           wr_en_dec, mem_en_dec, mem_rw_dec, branch_ex,
    input  stall_if, stall_dec, bubble_ex, flush, fwd_a_sel, fwd_b_sel, state_o
  );

  modport slave (
    input  valid_dec, RA_dec, RB_dec, uses_ra, uses_rb, RW_dec,
           wr_en_dec, mem_en_dec, mem_rw_dec, branch_ex,
    output stall_if, stall_dec, bubble_ex, flush, fwd_a_sel, fwd_b_sel, state_o
  );
endinterface

// File: rtl/hazard_sequencer_hazard_match.sv
// rtl/hazard_sequencer_hazard_match.sv - compares one source operand against one in-flight stage entry
module hazard_match #(
  parameter int AW = 5
) (
  input  logic [AW-1:0] src,
  input  logic          src_used,
  input  logic          ent_v,
  input  logic [AW-1:0] ent_rw,
  input  logic          ent_wr,
  output logic          hit
);
  // Register 0 is hard-wired, so it never creates a dependency.
  assign hit = src_used & ent_v & ent_wr & (ent_rw == src) & (src != '0);
endmodule

// File: rtl/hazard_sequencer.sv
// rtl/hazard_sequencer.sv - forwarding selects, load-use stall and branch flush sequencing for the 8-bit core
module hazard_sequencer
  import hazard_sequencer_pkg::*;
#(
  parameter int REG_AW       = 5,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  hazard_sequencer_if.slave bus
);

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rw;
    logic              wr;
    logic              ld;
  } entry_t;

  entry_t     dec_entry;
  entry_t     ex_q, ex_d, mem_q, mem_d;
  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic       a_ex_hit, a_mem_hit, b_ex_hit, b_mem_hit;
  logic       in_flush, load_hazard, bubble;

  hazard_match #(.AW(REG_AW)) u_a_ex (
    .src(bus.RA_dec), .src_used(bus.uses_ra), .ent_v(ex_q.v),
    .ent_rw(ex_q.rw), .ent_wr(ex_q.wr), .hit(a_ex_hit)
  );
  hazard_match #(.AW(REG_AW)) u_a_mem (
    .src(bus.RA_dec), .src_used(bus.uses_ra), .ent_v(mem_q.v),
    .ent_rw(mem_q.rw), .ent_wr(mem_q.wr), .hit(a_mem_hit)
  );
  hazard_match #(.AW(REG_AW)) u_b_ex (
    .src(bus.RB_dec), .src_used(bus.uses_rb), .ent_v(ex_q.v),
    .ent_rw(ex_q.rw), .ent_wr(ex_q.wr), .hit(b_ex_hit)
  );
  hazard_match #(.AW(REG_AW)) u_b_mem (
    .src(bus.RB_dec), .src_used(bus.uses_rb), .ent_v(mem_q.v),
    .ent_rw(mem_q.rw), .ent_wr(mem_q.wr), .hit(b_mem_hit)
  );

  always_comb begin
    dec_entry   = '{v: bus.valid_dec, rw: bus.RW_dec, wr: bus.wr_en_dec,
                    ld: bus.mem_en_dec & bus.mem_rw_dec};
    in_flush    = (state_q == ST_FLUSH);
    // Squashed slots in FLUSH cannot stall the front end.
    load_hazard = !in_flush && bus.valid_dec && ex_q.ld && (a_ex_hit || b_ex_hit);
    bubble      = in_flush || load_hazard;

    state_d = state_q;
    cnt_d   = cnt_q;
    if (in_flush) begin
      if (cnt_q == 2'd0) state_d = ST_RUN;
      else               cnt_d   = cnt_q - 2'd1;
    end else if (bus.branch_ex) begin
      state_d = ST_FLUSH;
      cnt_d   = 2'(FLUSH_CYCLES - 1);
    end

    ex_d    = bubble ? '0 : dec_entry;
    mem_d   = ex_q;
    // A load still in EX cannot forward; that case is covered by the stall.
    fwd_a_d = fwd_sel(bubble, a_ex_hit && !ex_q.ld, a_mem_hit);
    fwd_b_d = fwd_sel(bubble, b_ex_hit && !ex_q.ld, b_mem_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
      ex_q    <= '0;
      mem_q   <= '0;
      fwd_a_q <= FWD_REG;
      fwd_b_q <= FWD_REG;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.stall_if  = load_hazard;
  assign bus.stall_dec = load_hazard;
  assign bus.bubble_ex = bubble;
  assign bus.flush     = in_flush;
  assign bus.fwd_a_sel = fwd_a_q;
  assign bus.fwd_b_sel = fwd_b_q;
  assign bus.state_o   = state_q;

endmodule

// File: tb/tb_hazard_sequencer.sv
// tb/tb_hazard_sequencer.sv - directed vectors with a scoreboard queue and a decoupled negedge monitor
module tb_hazard_sequencer;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } sb_entry_t;

  logic      clk = 1'b0;
  logic      reset;
  sb_entry_t sb[$];
  int        n_checks = 0;
  int        n_fail   = 0;

  hazard_sequencer_if #(.REG_AW(5)) bus ();

  hazard_sequencer #(.REG_AW(5), .FLUSH_CYCLES(2)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // {stall_if, stall_dec, bubble_ex, flush, fwd_a_sel, fwd_b_sel, state_o}
  function automatic logic [9:0] E(input bit s, input bit b, input bit f,
                                   input logic [1:0] fa, input logic [1:0] fb,
                                   input logic [1:0] st);
    return {s, s, b, f, fa, fb, st};
  endfunction

  task automatic step(input string nm, input logic rst, input logic v,
                      input logic [4:0] ra, input logic ua,
                      input logic [4:0] rb, input logic ub,
                      input logic [4:0] rw, input logic wr,
                      input logic men, input logic mrw, input logic br,
                      input logic [9:0] exp);
    @(posedge clk);
    #1;
    reset          = rst;
    bus.valid_dec  = v;
    bus.RA_dec     = ra;
    bus.uses_ra    = ua;
    bus.RB_dec     = rb;
    bus.uses_rb    = ub;
    bus.RW_dec     = rw;
    bus.wr_en_dec  = wr;
    bus.mem_en_dec = men;
    bus.mem_rw_dec = mrw;
    bus.branch_ex  = br;
    sb.push_back('{name: nm, exp: exp});
  endtask

  task automatic idle(input string nm, input logic br, input logic [9:0] exp);
    step(nm, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, br, exp);
  endtask

  initial begin : monitor
    sb_entry_t  e;
    logic [9:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        act = {bus.stall_if, bus.stall_dec, bus.bubble_ex, bus.flush,
               bus.fwd_a_sel, bus.fwd_b_sel, bus.state_o};
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %b expected %b (si sd bub fl fa fb st)", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    reset          = 1'b1;
    bus.valid_dec  = 1'b0;
    bus.RA_dec     = '0;
    bus.uses_ra    = 1'b0;
    bus.RB_dec     = '0;
    bus.uses_rb    = 1'b0;
    bus.RW_dec     = '0;
    bus.wr_en_dec  = 1'b0;
    bus.mem_en_dec = 1'b0;
    bus.mem_rw_dec = 1'b0;
    bus.branch_ex  = 1'b0;

    //    name                rst v  ra     ua rb     ub rw     wr men mrw br  expected
    step("reset_1",           1, 0, 5'd0,  0, 5'd0,  0, 5'd0,  0, 0, 0, 0, E(0,0,0,0,0,0));
    step("reset_2",           1, 0, 5'd0,  0, 5'd0,  0, 5'd0,  0, 0, 0, 0, E(0,0,0,0,0,0));
    idle("idle_after_reset",  0, E(0,0,0,0,0,0));

    step("alu_w_r5",          0, 1, 5'd0,  0, 5'd0,  0, 5'd5,  1, 0, 0, 0, E(0,0,0,0,0,0));
    step("cons_ra_r5",        0, 1, 5'd5,  1, 5'd0,  0, 5'd6,  1, 0, 0, 0, E(0,0,0,0,0,0));
    idle("fwd_a_exmem",       0, E(0,0,0,1,0,0));
    step("alu_w_r5_b",        0, 1, 5'd0,  0, 5'd0,  0, 5'd5,  1, 0, 0, 0, E(0,0,0,0,0,0));
    step("unrelated_r7",      0, 1, 5'd0,  0, 5'd0,  0, 5'd7,  1, 0, 0, 0, E(0,0,0,0,0,0));
    step("cons_ra_r5_b",      0, 1, 5'd5,  1, 5'd0,  0, 5'd8,  1, 0, 0, 0, E(0,0,0,0,0,0));
    idle("fwd_a_memwb",       0, E(0,0,0,2,0,0));

    step("alu_w_r3",          0, 1, 5'd0,  0, 5'd0,  0, 5'd3,  1, 0, 0, 0, E(0,0,0,0,0,0));
    step("alu_w_r4",          0, 1, 5'd0,  0, 5'd0,  0, 5'd4,  1, 0, 0, 0, E(0,0,0,0,0,0));
    step("cons_ra3_rb4",      0, 1, 5'd3,  1, 5'd4,  1, 5'd14, 1, 0, 0, 0, E(0,0,0,0,0,0));
    idle("fwd_both",          0, E(0,0,0,2,1,0));

    step("store_nowr_r9",     0, 1, 5'd0,  0, 5'd0,  0, 5'd9,  0, 1, 0, 0, E(0,0,0,0,0,0));
    step("cons_ra_r9",        0, 1, 5'd9,  1, 5'd0,  0, 5'd11, 1, 0, 0, 0, E(0,0,0,0,0,0));
    idle("no_fwd_nowr",       0, E(0,0,0,0,0,0));

    step("load_r10",          0, 1, 5'd0,  0, 5'd0,  0, 5'd10, 1, 1, 1, 0, E(0,0,0,0,0,0));
    step("loaduse_stall",     0, 1, 5'd0,  0, 5'd10, 1, 5'd12, 1, 0, 0, 0, E(1,1,0,0,0,0));
    step("loaduse_issue",     0, 1, 5'd0,  0, 5'd10, 1, 5'd12, 1, 0, 0, 0, E(0,0,0,0,0,0));
    idle("fwd_b_after_load",  0, E(0,0,0,0,2,0));

    step("load_r0",           0, 1, 5'd0,  0, 5'd0,  0, 5'd0,  1, 1, 1, 0, E(0,0,0,0,0,0));
    step("cons_r0",           0, 1, 5'd0,  1, 5'd0,  1, 5'd13, 1, 0, 0, 0, E(0,0,0,0,0,0));
    idle("r0_no_fwd",         0, E(0,0,0,0,0,0));

    idle("branch",            1, E(0,0,0,0,0,0));
    idle("flush_1",           0, E(0,1,1,0,0,1));
    idle("flush_2_br_ignored",1, E(0,1,1,0,0,1));
    idle("run_after_flush",   0, E(0,0,0,0,0,0));
    idle("idle_run",          0, E(0,0,0,0,0,0));

    step("load_r10_b",        0, 1, 5'd0,  0, 5'd0,  0, 5'd10, 1, 1, 1, 0, E(0,0,0,0,0,0));
    step("br_over_stall",     0, 1, 5'd10, 1, 5'd0,  0, 5'd15, 1, 0, 0, 1, E(1,1,0,0,0,0));
    step("flush_b_1",         0, 1, 5'd10, 1, 5'd0,  0, 5'd15, 1, 0, 0, 0, E(0,1,1,0,0,1));
    idle("flush_b_2",         0, E(0,1,1,0,0,1));
    idle("run_b",             0, E(0,0,0,0,0,0));

    step("load_and_branch",   0, 1, 5'd0,  0, 5'd0,  0, 5'd10, 1, 1, 1, 1, E(0,0,0,0,0,0));
    step("rst_mid_flush",     1, 1, 5'd10, 1, 5'd0,  0, 5'd15, 1, 0, 0, 0, E(0,1,1,0,0,1));
    step("post_reset",        0, 1, 5'd10, 1, 5'd0,  0, 5'd15, 1, 0, 0, 0, E(0,0,0,0,0,0));
    idle("post_reset_fwd",    0, E(0,0,0,0,0,0));

    repeat (4) @(posedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_sequencer.md
Name: hazard_sequencer

Overview:
- Pipeline control block sitting between the decode stage and the execution block of the 8-bit pipelined core.
- Tracks destination registers of in-flight instructions in the EX, MEM and WB stages.
- Generates registered operand-forwarding selects, load-use stalls with bubble injection, and a timed flush after a taken branch.
- Sequences the execution block so that op_dec, A and B are valid, or are replaced by a NOP, every cycle.

Parameters:
- REG_AW, 5, register address width (matches RW_dec).
- FLUSH_CYCLES, 2, number of cycles flush stays high after a taken branch (legal range 1..3).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high; one clock; all state cleared on the clk edge where reset=1.
- valid_dec  in  1  decode holds a real instruction.
- RA_dec  in  REG_AW  source register A of the decode instruction.
- RB_dec  in  REG_AW  source register B of the decode instruction.
- uses_ra  in  1  decode instruction reads RA_dec.
- uses_rb  in  1  decode instruction reads RB_dec.
- RW_dec  in  REG_AW  destination register of the decode instruction.
- wr_en_dec  in  1  decode instruction writes RW_dec.
- mem_en_dec  in  1  decode instruction accesses memory.
- mem_rw_dec  in  1  1 = memory read (load), 0 = write.
- branch_ex  in  1  the instruction in EX is a taken branch, already resolved from flag_ex.
- stall_if  out  1  hold the PC.
- stall_dec  out  1  hold the IF/ID latch.
- bubble_ex  out  1  load a NOP (op 00000, mem_en 0, write disabled) into ID/EX.
- flush  out  1  squash IF/ID and ID/EX contents.
- fwd_a_sel  out  2  operand A source for the instruction currently in EX: 0 = regfile, 1 = EX/MEM ans_ex, 2 = MEM/WB data.
- fwd_b_sel  out  2  operand B source, same encoding as fwd_a_sel.
- state_o  out  2  current FSM state, for debug.

Behaviour:
- Internal stage entries ex_q, mem_q and wb_q, each holding {v, rw, wr, ld}.
  - Decode entry = {valid_dec, RW_dec, wr_en_dec, mem_en_dec & mem_rw_dec}.
  - Every edge: mem_q <= ex_q and wb_q <= mem_q.
  - ex_q <= decode entry, or an invalid entry when bubble_ex or flush is high.
- Hazard qualification: a source hits an entry if uses_x=1, entry.v=1, entry.wr=1, entry.rw == source, and source != 0. Register 0 never hazards.
- load_hazard (combinational): valid_dec and a source hits ex_q with ex_q.ld=1.
- FSM states: RUN=0, FLUSH=1.
- RUN state:
  - stall_if = stall_dec = bubble_ex = load_hazard (combinational, same cycle).
  - branch_ex=1 moves the FSM to FLUSH on the next edge and loads the counter with FLUSH_CYCLES-1.
  - branch_ex has priority over load_hazard: the stall outputs still reflect load_hazard in that cycle, but the FSM goes to FLUSH.
- FLUSH state:
  - flush=1 and bubble_ex=1; stall_if = stall_dec = 0.
  - The counter decrements each cycle; on counter==0 the FSM returns to RUN at the next edge.
  - branch_ex is ignored during FLUSH because squashed instructions cannot branch.
  - load_hazard is masked to 0 during FLUSH.
- Forwarding selects are registered and update on the same edge that loads ex_q, so they align with the instruction entering EX.
  - For each source: a hit on the old ex_q (non-load) gives 1; else a hit on the old mem_q gives 2; else 0. The nearest stage wins.
  - Selects are forced to 0 when bubble_ex or flush is high.
- Load-use sequence: one stall cycle with a bubble. On the next cycle the load sits in mem_q and the consumer issues with sel=2, giving a 1-cycle penalty.
- Reset, including mid-FLUSH or mid-stall: state=RUN, counter=0, all entries invalid, fwd selects=0. All outputs read 0 in the cycle after the reset edge.
- Simultaneous RA and RB hits are resolved independently per operand.

Decomposition:
- Shared package holds:
  - FSM state constants ST_RUN and ST_FLUSH.
  - Forwarding encodings FWD_REG=0, FWD_EXMEM=1, FWD_MEMWB=2.
  - The NOP opcode 5'b00000.
- One natural sub-module, hazard_match: a combinational comparator taking a source register, its use flag and one stage entry, and producing a hit. It is instantiated 4 times (RA and RB against ex_q and mem_q).

Test Plan:
1. Reset held 2 cycles, then released, with no instruction in flight: all outputs 0 and state_o=0.
2. ALU op writes R5, next instruction reads RA=R5: fwd_a_sel=1 in the consumer's EX cycle; with one unrelated instruction between them, fwd_a_sel=2.
3. Load to R10 followed by a consumer with RB=R10: stall_if, stall_dec and bubble_ex high for exactly 1 cycle, then fwd_b_sel=2 and no further stall.
4. Load to R0 followed by a consumer reading R0: no stall, fwd selects 0.
5. branch_ex pulse with FLUSH_CYCLES=2: flush and bubble_ex high for 2 cycles starting 1 cycle later; a branch_ex during FLUSH is ignored; state_o returns to 0.
6. Reset asserted in the middle of FLUSH while a load hazard is pending: the next cycle shows state_o=0, flush=0, stall_if=0, and fwd selects 0.
